fp_operand_issue: RTL and testbench

Operand fetch and issue stage that sits between the instruction source and the iterative DSP48E1 FP datapath, and wraps the 32x32 distributed-RAM register file. Each accepted instruction drives three read addresses into the register file, then captures the operands. A 32-entry scoreboard tracks pending destinations, so the stage stalls on RAW and WAW hazards. Writeback results from the FP unit are forwarded to the register file write port and bypassed into operands read in the same cycle.

---
 rtl/fp_operand_issue.sv | 145 ++++++++++++++
 tb/tb_fp_operand_issue.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_issue.sv
// Operand fetch/issue stage with a pending-destination scoreboard in front of the FP unit.
// Latency: an accepted instruction reaches ex_valid two edges later when it has no hazard (IDLE->CHECK->ISSUE).
// Backpressure: instr_ready is high only in IDLE; ISSUE holds every ex_* output until ex_ready; RAW/WAW hazards hold the stage in CHECK.
module fp_operand_issue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [OP_W-1:0]          instr_op,
  input  logic [ADDR_W-1:0]        instr_ra,
  input  logic [ADDR_W-1:0]        instr_rb,
  input  logic [ADDR_W-1:0]        instr_rc,
  input  logic [ADDR_W-1:0]        instr_rd,
  output logic [ADDR_W-1:0]        rf_addr_a,
  output logic [ADDR_W-1:0]        rf_addr_b,
  output logic [ADDR_W-1:0]        rf_addr_c,
  input  logic [DATA_W-1:0]        rf_do_a,
  input  logic [DATA_W-1:0]        rf_do_b,
  input  logic [DATA_W-1:0]        rf_do_c,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_addr_w,
  output logic [DATA_W-1:0]        rf_di,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [OP_W-1:0]          ex_op,
  output logic [DATA_W-1:0]        ex_a,
  output logic [DATA_W-1:0]        ex_b,
  output logic [DATA_W-1:0]        ex_c,
  output logic [ADDR_W-1:0]        ex_rd,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic [15:0]              stall_cnt,
  output logic                     err_spurious
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

  state_t            state;
  logic [OP_W-1:0]   ir_op;
  logic [ADDR_W-1:0] ir_ra;
  logic [ADDR_W-1:0] ir_rb;
  logic [ADDR_W-1:0] ir_rc;
  logic [ADDR_W-1:0] ir_rd;

  logic [NREG-1:0]   clr;
  logic [NREG-1:0]   eff;
  logic [NREG-1:0]   set_rd;
  logic              hazard;
  logic              capture;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] opnd_c;

  // Writeback goes straight to the register file; a result arriving during reset is dropped.
  assign rf_we     = wb_valid & ~rst;
  assign rf_addr_w = wb_rd;
  assign rf_di     = wb_data;

  // Read addresses come from the held instruction so the async RAM output is ready in CHECK.
  assign rf_addr_a = ir_ra;
  assign rf_addr_b = ir_rb;
  assign rf_addr_c = ir_rc;

  assign instr_ready = (state == IDLE);

  // Hazard test against the scoreboard as it will be after this cycle's writeback, plus operand bypass.
  always_comb begin
    clr = '0;
    if (wb_valid) clr[wb_rd] = 1'b1;
    eff     = pending & ~clr;
    hazard  = eff[ir_ra] | eff[ir_rb] | eff[ir_rc] | eff[ir_rd];
    capture = (state == CHECK) && !hazard;
    set_rd  = '0;
    if (capture) set_rd[ir_rd] = 1'b1;
    opnd_a = (wb_valid && (wb_rd == ir_ra)) ? wb_data : rf_do_a;
    opnd_b = (wb_valid && (wb_rd == ir_rb)) ? wb_data : rf_do_b;
    opnd_c = (wb_valid && (wb_rd == ir_rc)) ? wb_data : rf_do_c;
  end

  // Control FSM, scoreboard, stall counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ir_op        <= '0;
      ir_ra        <= '0;
      ir_rb        <= '0;
      ir_rc        <= '0;
      ir_rd        <= '0;
      ex_valid     <= 1'b0;
      ex_op        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_c         <= '0;
      ex_rd        <= '0;
      pending      <= '0;
      stall_cnt    <= '0;
      err_spurious <= 1'b0;
    end else begin
      // A new destination set in the same cycle as its clear leaves the bit set.
      pending <= eff | set_rd;
      if (wb_valid && !pending[wb_rd]) err_spurious <= 1'b1;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir_op <= instr_op;
            ir_ra <= instr_ra;
            ir_rb <= instr_rb;
            ir_rc <= instr_rc;
            ir_rd <= instr_rd;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (hazard) begin
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
          end else begin
            ex_op    <= ir_op;
            ex_rd    <= ir_rd;
            ex_a     <= opnd_a;
            ex_b     <= opnd_b;
            ex_c     <= opnd_c;
            ex_valid <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (ex_ready) begin
            ex_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_operand_issue.sv
// Bench for fp_operand_issue: it acts as register file and FP unit and runs a sequential reference model.
// Expected issues are queued at acceptance and popped by a separate monitor at each ex handshake.
// Randomised traffic plus directed latency, RAW/WAW, backpressure, spurious-writeback and reset cases.
module tb_fp_operand_issue;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 4;
  localparam int NR = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          instr_valid, instr_ready;
  logic [OW-1:0] instr_op;
  logic [AW-1:0] instr_ra, instr_rb, instr_rc, instr_rd;
  logic [AW-1:0] rf_addr_a, rf_addr_b, rf_addr_c, rf_addr_w;
  logic [DW-1:0] rf_do_a, rf_do_b, rf_do_c, rf_di;
  logic          rf_we;
  logic          ex_valid, ex_ready;
  logic [OW-1:0] ex_op;
  logic [DW-1:0] ex_a, ex_b, ex_c;
  logic [AW-1:0] ex_rd;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [NR-1:0] pending;
  logic [15:0]   stall_cnt;
  logic          err_spurious;

  fp_operand_issue #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rc(instr_rc), .instr_rd(instr_rd),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_addr_c(rf_addr_c),
    .rf_do_a(rf_do_a), .rf_do_b(rf_do_b), .rf_do_c(rf_do_c),
    .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_di(rf_di),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_c(ex_c), .ex_rd(ex_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .pending(pending), .stall_cnt(stall_cnt), .err_spurious(err_spurious)
  );

  // Register file: asynchronous read, synchronous write, plus a preload port for the bench.
  logic [DW-1:0] rf [NR];
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_dat = '0;
  assign rf_do_a = rf[rf_addr_a];
  assign rf_do_b = rf[rf_addr_b];
  assign rf_do_c = rf[rf_addr_c];
  always @(posedge clk) begin
    if (load_en) rf[load_addr] <= load_dat;
    else if (rf_we) rf[rf_addr_w] <= rf_di;
  end

  typedef struct packed {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [AW-1:0] rd;
  } exp_t;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    int            due;
  } res_t;

  exp_t          exp_q[$];
  res_t          res_q[$];
  logic [DW-1:0] m_reg [NR];
  int            errors = 0;
  int            checks = 0;

  logic          emu_hold = 1'b0;
  logic          emu_nowb = 1'b0;
  logic          inj_req  = 1'b0;
  logic [AW-1:0] inj_rd   = '0;
  logic [DW-1:0] inj_dat  = '0;

  // Arbitrary deterministic stand-in for the FP operation.
  function automatic logic [DW-1:0] fpu(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic [DW-1:0] c);
    return (a * 32'd3) ^ (b + c) ^ {28'd0, op} ^ 32'h5A5A0000;
  endfunction

  function automatic logic [AW-1:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Offer one instruction (called at a falling edge); the model executes it in program order.
  task automatic send(input logic [OW-1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic [AW-1:0] rc, input logic [AW-1:0] rd);
    int n = 0;
    while (!instr_ready && n < 300) begin @(negedge clk); n++; end
    if (!instr_ready) begin fail_now("send_ready"); return; end
    instr_valid = 1'b1;
    instr_op = op; instr_ra = ra; instr_rb = rb; instr_rc = rc; instr_rd = rd;
    exp_q.push_back('{op: op, a: m_reg[ra], b: m_reg[rb], c: m_reg[rc], rd: rd});
    m_reg[rd] = fpu(op, m_reg[ra], m_reg[rb], m_reg[rc]);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || res_q.size() != 0 || !instr_ready) && n < 600) begin
      @(negedge clk); n++;
    end
    if (n >= 600) fail_now("drain");
  endtask

  task automatic wait_ex_valid(input string name);
    int n = 0;
    while (!ex_valid && n < 100) begin @(negedge clk); n++; end
    if (!ex_valid) fail_now(name);
  endtask

  task automatic wait_handshake(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) fail_now(name);
  endtask

  // FP unit emulator: random accept, results returned after a random delay, one per cycle.
  initial begin
    int cyc = 0;
    ex_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    forever begin
      @(negedge clk); #1;
      wb_valid = 1'b0;
      cyc++;
      if (rst) begin
        res_q.delete();
        ex_ready = 1'b0;
      end else begin
        ex_ready = !emu_hold && ($urandom_range(0, 9) < 7);
        if (ex_valid && ex_ready)
          res_q.push_back('{rd: ex_rd, data: fpu(ex_op, ex_a, ex_b, ex_c), due: cyc + int'($urandom_range(1, 6))});
        if (inj_req) begin
          wb_valid = 1'b1; wb_rd = inj_rd; wb_data = inj_dat; inj_req = 1'b0;
        end else if (!emu_nowb) begin
          for (int i = 0; i < res_q.size(); i++) begin
            if (res_q[i].due <= cyc) begin
              wb_valid = 1'b1; wb_rd = res_q[i].rd; wb_data = res_q[i].data;
              res_q.delete(i);
              break;
            end
          end
        end
      end
    end
  end

  // Monitor: scoreboard pops at each ex handshake, pending set tracked from issues and writebacks.
  initial begin
    logic [NR-1:0] m_pend = '0;
    logic          prev_exv = 1'b0;
    logic          last_wb_v = 1'b0;
    logic [AW-1:0] last_wb_rd = '0;
    logic          rst_at_edge = 1'b1;
    exp_t          e;
    forever begin
      @(negedge clk); #2;
      if (rst_at_edge) begin
        m_pend = '0; prev_exv = 1'b0;
      end else begin
        if (last_wb_v) m_pend[last_wb_rd] = 1'b0;
        if (ex_valid && !prev_exv && exp_q.size() > 0) m_pend[exp_q[0].rd] = 1'b1;
        prev_exv = ex_valid;
      end
      chk("pending", pending, m_pend);
      chk("wr_port", {rf_we, rf_addr_w, rf_di}, {wb_valid && !rst, wb_rd, wb_data});
      if (ex_valid && ex_ready && !rst) begin
        if (exp_q.size() == 0) fail_now("unexpected_issue");
        else begin
          e = exp_q.pop_front();
          chk("issue", {ex_op, ex_a, ex_b, ex_c, ex_rd}, e);
        end
      end
      last_wb_v = wb_valid && !rst;
      last_wb_rd = wb_rd;
      rst_at_edge = rst;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by randomised traffic.
  initial begin
    int s0;
    rst = 1'b1; instr_valid = 1'b0;
    instr_op = '0; instr_ra = '0; instr_rb = '0; instr_rc = '0; instr_rd = '0;
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = AW'(i);
      load_dat = (i == 3) ? 32'h3F800000 : (i == 4) ? 32'h40000000 : $urandom;
      m_reg[i] = load_dat;
    end
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_pending", pending, '0);
    chk("rst_instr_ready", instr_ready, 1'b1);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_err", err_spurious, 1'b0);
    chk("rst_ex_fields", {ex_op, ex_a, ex_rd, rf_addr_a}, '0);
    rst = 1'b0;
    @(negedge clk);

    // First issue: one cycle in CHECK, ex_valid visible after the second edge.
    send(4'd2, 5'd3, 5'd4, 5'd0, 5'd5);
    chk("lat_check_cycle", ex_valid, 1'b0);
    @(negedge clk);
    chk("lat_issue", ex_valid, 1'b1);
    chk("lat_ex_a", ex_a, 32'h3F800000);
    chk("lat_ex_b", ex_b, 32'h40000000);
    chk("lat_pend5", pending[5], 1'b1);
    drain();

    // RAW: consumer of r5 stalls while r5's result is withheld, then takes the bypass.
    emu_nowb = 1'b1;
    send(4'd1, 5'd1, 5'd2, 5'd3, 5'd5);
    wait_handshake("raw_producer");
    s0 = stall_cnt;
    send(4'd3, 5'd5, 5'd1, 5'd2, 5'd8);
    repeat (6) @(negedge clk);
    chk("raw_stall_cnt", stall_cnt, 16'(s0 + 6));
    chk("raw_no_issue", {ex_valid, instr_ready}, 2'b00);
    emu_nowb = 1'b0;
    drain();

    // WAW: second writer of r5 waits for the first result, then re-marks r5.
    emu_nowb = 1'b1;
    send(4'd4, 5'd2, 5'd3, 5'd4, 5'd5);
    wait_handshake("waw_first");
    send(4'd5, 5'd1, 5'd2, 5'd3, 5'd5);
    repeat (3) @(negedge clk);
    chk("waw_stall", ex_valid, 1'b0);
    emu_nowb = 1'b0;
    wait_ex_valid("waw_issue");
    chk("waw_pend5", pending[5], 1'b1);
    drain();

    // Backpressure: ex outputs frozen for 10 cycles while r6's result lands.
    emu_nowb = 1'b1;
    send(4'd6, 5'd0, 5'd1, 5'd2, 5'd6);
    wait_handshake("bp_first");
    emu_hold = 1'b1;
    send(4'd7, 5'd1, 5'd2, 5'd3, 5'd7);
    wait_ex_valid("bp_issue");
    emu_nowb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) fail_now("bp_queue");
      else chk("bp_ex_stable", {ex_op, ex_a, ex_b, ex_c, ex_rd}, exp_q[0]);
      chk("bp_instr_ready", {ex_valid, instr_ready}, 2'b10);
    end
    chk("bp_pend6_cleared", pending[6], 1'b0);
    chk("bp_pend7_held", pending[7], 1'b1);
    emu_hold = 1'b0;
    drain();

    // Writeback to a register nobody is waiting on.
    chk("err_before_spurious", err_spurious, 1'b0);
    inj_rd = 5'd9; inj_dat = 32'hDEADBEEF; inj_req = 1'b1;
    m_reg[9] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    chk("err_spurious_set", err_spurious, 1'b1);
    chk("spurious_rf_write", rf[9], 32'hDEADBEEF);

    // Random program.
    for (int n = 0; n < 250; n++) begin
      send(OW'($urandom_range(0, 15)), rnd_reg(), rnd_reg(), rnd_reg(), rnd_reg());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    chk("err_sticky", err_spurious, 1'b1);

    // Reset while an instruction sits in ISSUE with r7 pending.
    emu_hold = 1'b1;
    send(4'd9, 5'd1, 5'd2, 5'd3, 5'd7);
    wait_ex_valid("rst_issue");
    chk("pre_rst_pend7", pending[7], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) m_reg[i] = rf[i];
    chk("post_rst_ex_valid", ex_valid, 1'b0);
    chk("post_rst_pending", pending, '0);
    chk("post_rst_ready", instr_ready, 1'b1);
    chk("post_rst_stall", stall_cnt, 16'd0);
    chk("post_rst_err", err_spurious, 1'b0);
    emu_hold = 1'b0;
    for (int n = 0; n < 20; n++) send(OW'(n), rnd_reg(), rnd_reg(), rnd_reg(), rnd_reg());
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
